// File: rtl/framebuffer_responder_if.sv
// Pixel-stream and memory-load signal bundle between the VGA generator side (master)
// and the framebuffer responder (slave).
interface framebuffer_responder_if #(
  parameter int ADDR_W = 12
);
  logic              frame_next_pixel_in;
  logic              frame_reset_in;
  logic [3:0]        frame_pixel_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic              frame_active;
  logic              overrun;

  modport master (
    output frame_next_pixel_in, frame_reset_in, wr_en, wr_addr, wr_data,
    input  frame_pixel_out, frame_active, overrun
  );

  modport slave (
    input  frame_next_pixel_in, frame_reset_in, wr_en, wr_addr, wr_data,
    output frame_pixel_out, frame_active, overrun
  );
endinterface

// File: rtl/framebuffer_responder.sv
// 4-bit grayscale framebuffer that serves one pixel per advance edge to the VGA generator.
// Optional macro FB_SYNC_INPUTS_EN adds 2-flop synchronizers on the two stream control inputs.
module framebuffer_responder #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12
) (
  input logic                   clk,
  input logic                   rst_n,
  framebuffer_responder_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic              overrun_nxt;
  logic              next_prev;
  logic              next_s, rewind_s, advance;
  logic [3:0]        mem [DEPTH];

`ifdef FB_SYNC_INPUTS_EN
  logic [1:0] next_sync, rewind_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_sync   <= 2'b00;
      rewind_sync <= 2'b00;
    end else begin
      next_sync   <= {next_sync[0], bus.frame_next_pixel_in};
      rewind_sync <= {rewind_sync[0], bus.frame_reset_in};
    end
  end

  assign next_s   = next_sync[1];
  assign rewind_s = rewind_sync[1];
`else
  assign next_s   = bus.frame_next_pixel_in;
  assign rewind_s = bus.frame_reset_in;
`endif

  // A held-high request yields a single advance: only the 0->1 transition counts.
  assign advance = next_s & ~next_prev;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt   = state;
    rd_addr_nxt = rd_addr;
    overrun_nxt = bus.overrun;
    unique case (state)
      IDLE: begin
        if (rewind_s) begin
          state_nxt   = STREAM;
          rd_addr_nxt = '0;
        end
      end
      STREAM: begin
        if (rewind_s) begin
          rd_addr_nxt = '0;
        end else if (advance) begin
          if (rd_addr == LAST_ADDR) begin
            rd_addr_nxt = '0;
            overrun_nxt = 1'b1;
          end else begin
            rd_addr_nxt = rd_addr + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    if (!rst_n) begin
      state               <= IDLE;
      rd_addr             <= '0;
      next_prev           <= 1'b0;
      bus.frame_pixel_out <= 4'h0;
      bus.frame_active    <= 1'b0;
      bus.overrun         <= 1'b0;
    end else begin
      state               <= state_nxt;
      rd_addr             <= rd_addr_nxt;
      next_prev           <= next_s;
      bus.overrun         <= overrun_nxt;
      bus.frame_active    <= (state_nxt == STREAM);
      // Reads the pre-edge memory word, which makes a same-address write read-first.
      bus.frame_pixel_out <= (state == STREAM) ? mem[rd_addr] : 4'h0;
    end
  end

  // NOTE: the pixel array has no reset so it maps onto plain RAM and survives rst_n.
  always_ff @(posedge clk) begin
    if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_EXT)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_framebuffer_responder.sv
// Randomized self-checking bench for framebuffer_responder against a pointer/array model.
// Honors FB_SYNC_INPUTS_EN by delaying the model's view of the stream controls by 2 clk.
module tb_framebuffer_responder;
  localparam int D  = 48;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  framebuffer_responder_if #(.ADDR_W(AW)) bus ();

  framebuffer_responder #(.DEPTH(D), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a plain pixel array, an integer read pointer and a few flags.
  logic [3:0] m_mem [D];
  int         m_ptr;
  bit         m_stream, m_ovr, m_prev;
  bit [1:0]   s_nx, s_rw;
  logic [3:0] exp_pix;

  task automatic m_reset();
    m_ptr = 0; m_stream = 0; m_ovr = 0; m_prev = 0;
    s_nx = 2'b00; s_rw = 2'b00; exp_pix = 4'h0;
  endtask

  task automatic model_edge();
    bit nx, rw;
`ifdef FB_SYNC_INPUTS_EN
    nx = s_nx[1]; rw = s_rw[1];
    s_nx = {s_nx[0], bus.frame_next_pixel_in};
    s_rw = {s_rw[0], bus.frame_reset_in};
`else
    nx = bus.frame_next_pixel_in; rw = bus.frame_reset_in;
`endif
    exp_pix = m_stream ? m_mem[m_ptr] : 4'h0;
    if (rw) begin
      m_stream = 1; m_ptr = 0;
    end else if (m_stream && nx && !m_prev) begin
      if (m_ptr + 1 == D) m_ovr = 1;
      m_ptr = (m_ptr + 1) % D;
    end
    m_prev = nx;
    if (bus.wr_en && int'(bus.wr_addr) < D) m_mem[bus.wr_addr] = bus.wr_data;
  endtask

  // One clock: inputs already set at the negedge, model follows the posedge, return at negedge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.frame_next_pixel_in = 0; bus.frame_reset_in = 0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    m_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.frame_pixel_out !== 4'h0) begin bad++; $display("FAIL reset_pix: got %h want 0", bus.frame_pixel_out); end
    total++; if (bus.frame_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", bus.frame_active); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_load();
    for (int i = 0; i < D; i++) begin
      bus.wr_en = 1; bus.wr_addr = AW'(i);
      bus.wr_data = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      cyc();
      total++; if (bus.frame_pixel_out !== 4'h0) begin bad++; $display("FAIL load_pix: got %h want 0", bus.frame_pixel_out); end
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_idle_ignores();
    for (int p = 0; p < 3; p++) begin
      bus.frame_next_pixel_in = 1; cyc();
      bus.frame_next_pixel_in = 0; cyc(); cyc();
      total++; if ({bus.frame_pixel_out, bus.frame_active} !== 5'h00) begin bad++; $display("FAIL idle: got pix=%h act=%b want pix=0 act=0", bus.frame_pixel_out, bus.frame_active); end
    end
  endtask

  task automatic test_advance();
    bus.frame_reset_in = 1; cyc();
    bus.frame_reset_in = 0; repeat (4) cyc();
    total++; if (bus.frame_pixel_out !== 4'h0) begin bad++; $display("FAIL adv_start: got %h want 0", bus.frame_pixel_out); end
    for (int p = 1; p <= 5; p++) begin
      bus.frame_next_pixel_in = 1; cyc();
      bus.frame_next_pixel_in = 0;
      for (int k = 0; k < 3; k++) begin
        cyc();
        total++; if ({bus.frame_pixel_out, bus.frame_active, bus.overrun} !== {exp_pix, m_stream, m_ovr}) begin bad++; $display("FAIL adv_cycle: got pix=%h act=%b ovr=%b want pix=%h act=%b ovr=%b", bus.frame_pixel_out, bus.frame_active, bus.overrun, exp_pix, m_stream, m_ovr); end
      end
      total++; if (bus.frame_pixel_out !== 4'(p)) begin bad++; $display("FAIL adv_value: got %h want %h", bus.frame_pixel_out, 4'(p)); end
    end
    total++; if (bus.frame_active !== 1'b1) begin bad++; $display("FAIL adv_active: got %b want 1", bus.frame_active); end
  endtask

  task automatic test_hold();
    bus.frame_next_pixel_in = 1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      total++; if (bus.frame_pixel_out !== exp_pix) begin bad++; $display("FAIL hold_cycle: got %h want %h", bus.frame_pixel_out, exp_pix); end
    end
    bus.frame_next_pixel_in = 0; repeat (3) cyc();
    total++; if (bus.frame_pixel_out !== 4'h6) begin bad++; $display("FAIL hold_value: got %h want 6", bus.frame_pixel_out); end
  endtask

  task automatic test_rewind_collision();
    bus.frame_reset_in = 1; bus.frame_next_pixel_in = 1; cyc();
    bus.frame_reset_in = 0; bus.frame_next_pixel_in = 0;
    repeat (4) cyc();
    total++; if (bus.frame_pixel_out !== 4'h0) begin bad++; $display("FAIL rewind_pix: got %h want 0", bus.frame_pixel_out); end
    bus.frame_next_pixel_in = 1; cyc();
    bus.frame_next_pixel_in = 0; repeat (3) cyc();
    total++; if (bus.frame_pixel_out !== 4'h1) begin bad++; $display("FAIL rewind_drop: got %h want 1", bus.frame_pixel_out); end
  endtask

  task automatic test_wrap();
    bus.frame_reset_in = 1; cyc();
    bus.frame_reset_in = 0; repeat (3) cyc();
    for (int p = 0; p < D; p++) begin
      bus.frame_next_pixel_in = 1; cyc();
      bus.frame_next_pixel_in = 0; cyc();
      total++; if ({bus.frame_pixel_out, bus.overrun} !== {exp_pix, m_ovr}) begin bad++; $display("FAIL wrap_cycle: got pix=%h ovr=%b want pix=%h ovr=%b", bus.frame_pixel_out, bus.overrun, exp_pix, m_ovr); end
    end
    repeat (3) cyc();
    total++; if ({bus.frame_pixel_out, bus.overrun} !== {4'h0, 1'b1}) begin bad++; $display("FAIL wrap_end: got pix=%h ovr=%b want pix=0 ovr=1", bus.frame_pixel_out, bus.overrun); end
    bus.frame_reset_in = 1; cyc();
    bus.frame_reset_in = 0; repeat (3) cyc();
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
  endtask

  task automatic test_write_collision();
    for (int p = 0; p < 7; p++) begin
      bus.frame_next_pixel_in = 1; cyc();
      bus.frame_next_pixel_in = 0; repeat (3) cyc();
    end
    total++; if (bus.frame_pixel_out !== 4'h7) begin bad++; $display("FAIL coll_pre: got %h want 7", bus.frame_pixel_out); end
    bus.wr_en = 1; bus.wr_addr = AW'(7); bus.wr_data = 4'hA; cyc();
    total++; if (bus.frame_pixel_out !== 4'h7) begin bad++; $display("FAIL coll_old: got %h want 7", bus.frame_pixel_out); end
    bus.wr_addr = AW'(D); bus.wr_data = 4'h5; cyc();
    total++; if (bus.frame_pixel_out !== 4'hA) begin bad++; $display("FAIL coll_new: got %h want A", bus.frame_pixel_out); end
    idle_inputs(); cyc();
    total++; if (bus.frame_pixel_out !== exp_pix) begin bad++; $display("FAIL oob_write: got %h want %h", bus.frame_pixel_out, exp_pix); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 0;
    #1;
    total++; if ({bus.frame_pixel_out, bus.frame_active, bus.overrun} !== 6'h00) begin bad++; $display("FAIL async_reset: got pix=%h act=%b ovr=%b want all 0", bus.frame_pixel_out, bus.frame_active, bus.overrun); end
    m_reset();
    @(negedge clk); rst_n = 1;
    bus.frame_next_pixel_in = 1; cyc();
    bus.frame_next_pixel_in = 0; repeat (3) cyc();
    total++; if ({bus.frame_pixel_out, bus.frame_active} !== 5'h00) begin bad++; $display("FAIL post_reset_idle: got pix=%h act=%b want 0 0", bus.frame_pixel_out, bus.frame_active); end
    bus.frame_reset_in = 1; cyc();
    bus.frame_reset_in = 0;
    for (int p = 0; p < 7; p++) begin
      bus.frame_next_pixel_in = 1; cyc();
      bus.frame_next_pixel_in = 0; repeat (3) cyc();
    end
    total++; if (bus.frame_pixel_out !== 4'hA) begin bad++; $display("FAIL mem_retained: got %h want A", bus.frame_pixel_out); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.frame_next_pixel_in = 1'($urandom_range(0, 1));
      bus.frame_reset_in      = ($urandom_range(0, 19) == 0);
      bus.wr_en               = ($urandom_range(0, 3) == 0);
      bus.wr_addr             = AW'($urandom_range(0, D + 8));
      bus.wr_data             = 4'($urandom_range(0, 15));
      cyc();
      total++; if ({bus.frame_pixel_out, bus.frame_active, bus.overrun} !== {exp_pix, m_stream, m_ovr}) begin bad++; $display("FAIL random: got pix=%h act=%b ovr=%b want pix=%h act=%b ovr=%b", bus.frame_pixel_out, bus.frame_active, bus.overrun, exp_pix, m_stream, m_ovr); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    test_reset();
    test_load();
    test_idle_ignores();
    test_advance();
    test_hold();
    test_rewind_collision();
    test_wrap();
    test_write_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
